// File: rtl/imu_link_pkg.sv
// Shared types and widths for the sensor packet scheduler.
// Holds the scheduler state encoding and counter widths.
package imu_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_TRIGGER,
      ST_SENDING,
      ST_HOLDOFF
   } state_t;

   localparam int PKT_W  = 16;
   localparam int DROP_W = 8;
   localparam int ERR_W  = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sensor_packet_scheduler.sv
// Pairs two sensor samples into a packet, triggers the formatter
// and polices it with a busy watchdog and a holdoff interval.
module sensor_packet_scheduler
   import imu_link_pkg::*;
#(
   parameter int MIN_INTERVAL = 1000,
   parameter int PAIR_TIMEOUT = 50000,
   parameter int BUSY_TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              sensor1_valid,
   input  logic              sensor2_valid,
   input  logic              fmt_busy,
   output logic              data_ready,
   output logic              fmt_abort,
   output logic [1:0]        missing,
   output logic [PKT_W-1:0]  pkt_count,
   output logic [DROP_W-1:0] drop_count,
   output logic [ERR_W-1:0]  err_count
);

   localparam int TMAX = max3(MIN_INTERVAL, PAIR_TIMEOUT, BUSY_TIMEOUT);
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] PAIR_LIM  = TW'(PAIR_TIMEOUT);
   localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TIMEOUT - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(MIN_INTERVAL - 1);

   state_t          state;
   logic [TW-1:0]   timer;
   logic            have1;
   logic            have2;
   logic            any_have;
   logic            new_any;
   logic            abort_now;
   logic [1:0]      drop_inc;
   logic [DROP_W:0] drop_sum;

   always_comb begin
      any_have = have1 | have2;
      new_any  = any_have | sensor1_valid | sensor2_valid;
      drop_inc = {1'b0, sensor1_valid & have1}
               + {1'b0, sensor2_valid & have2};
      drop_sum = {1'b0, drop_count}
               + {{(DROP_W - 1){1'b0}}, drop_inc};
      abort_now = (timer == BUSY_LAST) &&
                  (((state == ST_TRIGGER) && !fmt_busy) ||
                   ((state == ST_SENDING) && fmt_busy));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         timer      <= '0;
         have1      <= 1'b0;
         have2      <= 1'b0;
         data_ready <= 1'b0;
         fmt_abort  <= 1'b0;
         missing    <= 2'b00;
         pkt_count  <= '0;
         drop_count <= '0;
         err_count  <= '0;
      end else begin
         fmt_abort <= 1'b0;
         if ((state != ST_IDLE) && (drop_inc != 2'd0))
            drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
         unique case (state)
            ST_IDLE: begin
               have1 <= 1'b0;
               have2 <= 1'b0;
               timer <= '0;
               if (enable)
                  state <= ST_COLLECT;
            end
            ST_COLLECT: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if ((have1 & have2) ||
                            (any_have && (timer == PAIR_LIM))) begin
                  state      <= ST_TRIGGER;
                  missing    <= ~{have2, have1};
                  have1      <= sensor1_valid;
                  have2      <= sensor2_valid;
                  data_ready <= 1'b1;
                  timer      <= '0;
               end else begin
                  have1 <= have1 | sensor1_valid;
                  have2 <= have2 | sensor2_valid;
                  timer <= new_any ? timer + TW'(1) : '0;
               end
            end
            ST_TRIGGER, ST_SENDING: begin
               have1 <= have1 | sensor1_valid;
               have2 <= have2 | sensor2_valid;
               if (abort_now) begin
                  fmt_abort  <= 1'b1;
                  data_ready <= 1'b0;
                  if (err_count != '1)
                     err_count <= err_count + ERR_W'(1);
                  state <= enable ? ST_HOLDOFF : ST_IDLE;
                  timer <= '0;
               end else if ((state == ST_TRIGGER) && fmt_busy) begin
                  data_ready <= 1'b0;
                  state      <= ST_SENDING;
                  timer      <= '0;
               end else if ((state == ST_SENDING) && !fmt_busy) begin
                  pkt_count <= pkt_count + PKT_W'(1);
                  state     <= enable ? ST_HOLDOFF : ST_IDLE;
                  timer     <= '0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ST_HOLDOFF: begin
               have1 <= have1 | sensor1_valid;
               have2 <= have2 | sensor2_valid;
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (timer == HOLD_LAST) begin
                  // pair timer restarts here if a sample is already waiting
                  state <= ST_COLLECT;
                  timer <= new_any ? TW'(1) : '0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
